// File: rtl/canvas_arbiter.sv
// canvas_arbiter
//   Arbitrates one synchronous canvas RAM between three requesters. From
//   highest to lowest priority they are the VGA scan-out reads, the
//   full-canvas wipe engine and the joystick paint writes. The block maps
//   640x480 screen coordinates onto canvas cells. A VGA request always
//   returns its colour exactly three cycles later.
//
// Ports
//   clk, clr                  system clock, asynchronous active-high reset
//   vga_req/vga_x/vga_y       pixel read request for this cycle
//   vga_valid/vga_color       read result, three cycles after the request
//   paint_req/_x/_y/_color    level paint request, held until paint_ack
//   paint_ack                 one-cycle pulse, paint request consumed
//   wipe_req/wipe_color       start a full-canvas fill with wipe_color
//   wiping                    fill in progress
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   canvas RAM port
module canvas_arbiter #(
  parameter int CANVAS_W    = 160,
  parameter int CANVAS_H    = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int COLOR_W     = 3,
  parameter int ADDR_W      = 15
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               vga_req,
  input  logic [9:0]         vga_x,
  input  logic [9:0]         vga_y,
  output logic               vga_valid,
  output logic [COLOR_W-1:0] vga_color,
  input  logic               paint_req,
  input  logic [9:0]         paint_x,
  input  logic [9:0]         paint_y,
  input  logic [COLOR_W-1:0] paint_color,
  output logic               paint_ack,
  input  logic               wipe_req,
  input  logic [COLOR_W-1:0] wipe_color,
  output logic               wiping,
  output logic               ram_en,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [COLOR_W-1:0] ram_wdata,
  input  logic [COLOR_W-1:0] ram_rdata
);

  localparam int X_LIM = CANVAS_W << SCALE_SHIFT;
  localparam int Y_LIM = CANVAS_H << SCALE_SHIFT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CANVAS_W * CANVAS_H - 1);

  typedef enum logic {IDLE, WIPE} state_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] x, input logic [9:0] y);
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    row = ADDR_W'(y >> SCALE_SHIFT);
    col = ADDR_W'(x >> SCALE_SHIFT);
    return row * ADDR_W'(CANVAS_W) + col;
  endfunction

  function automatic logic in_range(input logic [9:0] x, input logic [9:0] y);
    return (32'(x) < X_LIM) && (32'(y) < Y_LIM);
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wipe_addr_q, wipe_addr_d;
  logic [COLOR_W-1:0]  wipe_color_q, wipe_color_d;
  logic                wiping_q, wiping_d;
  logic                paint_ack_q, paint_ack_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [COLOR_W-1:0]  ram_wdata_q, ram_wdata_d;
  // Read pipeline: s1 = RAM access cycle, s2 = RAM data cycle.
  logic                vga_s1_q, vga_s1_d, vga_oor_s1_q, vga_oor_s1_d;
  logic                vga_s2_q, vga_s2_d, vga_oor_s2_q, vga_oor_s2_d;
  logic                vga_valid_q, vga_valid_d;
  logic [COLOR_W-1:0]  vga_color_q, vga_color_d;

  logic                start_wipe, wipe_active, wipe_grant, wipe_last, paint_grant;
  logic [ADDR_W-1:0]   wipe_slot_addr;
  logic [COLOR_W-1:0]  wipe_slot_color;

  // NOTE: every signal gets a default at the top of the block so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    wipe_addr_d  = wipe_addr_q;
    wipe_color_d = wipe_color_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = '0;
    ram_wdata_d  = '0;

    // The tail cycle (final write on the bus, wiping still high) counts as
    // busy, so neither a new wipe nor a paint can slip in there.
    start_wipe  = (state_q == IDLE) && !wiping_q && wipe_req;
    wipe_active = (state_q == WIPE) || start_wipe;
    // The start cycle already owns a write slot: address 0, live colour.
    wipe_slot_addr  = start_wipe ? '0 : wipe_addr_q;
    wipe_slot_color = start_wipe ? wipe_color : wipe_color_q;
    wipe_grant      = wipe_active && !vga_req;
    wipe_last       = wipe_grant && (wipe_slot_addr == LAST_ADDR);
    // Requests seen while ack is high are the same request still held.
    paint_grant = paint_req && !paint_ack_q && !vga_req && !wipe_active && !wiping_q;

    if (vga_req) begin
      // An out-of-range pixel keeps the slot but touches no RAM.
      if (in_range(vga_x, vga_y)) begin
        ram_en_d   = 1'b1;
        ram_addr_d = cell_addr(vga_x, vga_y);
      end
    end else if (wipe_grant) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      ram_addr_d  = wipe_slot_addr;
      ram_wdata_d = wipe_slot_color;
    end else if (paint_grant && in_range(paint_x, paint_y)) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      ram_addr_d  = cell_addr(paint_x, paint_y);
      ram_wdata_d = paint_color;
    end

    if (start_wipe) begin
      state_d      = WIPE;
      wipe_color_d = wipe_color;
      wipe_addr_d  = '0;
    end
    // A slot lost to VGA leaves wipe_addr where it was.
    if (wipe_grant) begin
      wipe_addr_d = wipe_slot_addr + 1'b1;
      if (wipe_last) state_d = IDLE;
    end

    // Stay high through the cycle that carries the final write.
    wiping_d    = (state_d == WIPE) || wipe_last;
    paint_ack_d = paint_grant;

    vga_s1_d     = vga_req;
    vga_oor_s1_d = vga_req && !in_range(vga_x, vga_y);
    vga_s2_d     = vga_s1_q;
    vga_oor_s2_d = vga_oor_s1_q;
    vga_valid_d  = vga_s2_q;
    vga_color_d  = (vga_s2_q && !vga_oor_s2_q) ? ram_rdata : '0;
  end

  // NOTE: state updates use non-blocking assignments so that all flops
  // sample the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      wipe_addr_q  <= '0;
      wipe_color_q <= '0;
      wiping_q     <= 1'b0;
      paint_ack_q  <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      vga_s1_q     <= 1'b0;
      vga_oor_s1_q <= 1'b0;
      vga_s2_q     <= 1'b0;
      vga_oor_s2_q <= 1'b0;
      vga_valid_q  <= 1'b0;
      vga_color_q  <= '0;
    end else begin
      state_q      <= state_d;
      wipe_addr_q  <= wipe_addr_d;
      wipe_color_q <= wipe_color_d;
      wiping_q     <= wiping_d;
      paint_ack_q  <= paint_ack_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      vga_s1_q     <= vga_s1_d;
      vga_oor_s1_q <= vga_oor_s1_d;
      vga_s2_q     <= vga_s2_d;
      vga_oor_s2_q <= vga_oor_s2_d;
      vga_valid_q  <= vga_valid_d;
      vga_color_q  <= vga_color_d;
    end
  end

  assign vga_valid = vga_valid_q;
  assign vga_color = vga_color_q;
  assign paint_ack = paint_ack_q;
  assign wiping    = wiping_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_canvas_arbiter.sv
// Directed bench for canvas_arbiter with a behavioural synchronous RAM.
module tb_canvas_arbiter;

  logic        clk;
  logic        clr;
  logic        vga_req;
  logic [9:0]  vga_x, vga_y;
  logic        vga_valid;
  logic [2:0]  vga_color;
  logic        paint_req;
  logic [9:0]  paint_x, paint_y;
  logic [2:0]  paint_color;
  logic        paint_ack;
  logic        wipe_req;
  logic [2:0]  wipe_color;
  logic        wiping;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [2:0]  ram_wdata;
  logic [2:0]  ram_rdata;

  logic        pre_we;
  logic [14:0] pre_addr;
  logic [2:0]  pre_data;
  logic [2:0]  mem [0:32767];

  logic [25:0] all_outs;
  assign all_outs = {vga_valid, vga_color, paint_ack, wiping, ram_en, ram_we, ram_addr, ram_wdata};

  int vectors;
  int miscompares;

  canvas_arbiter dut (
    .clk(clk), .clr(clr),
    .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y),
    .vga_valid(vga_valid), .vga_color(vga_color),
    .paint_req(paint_req), .paint_x(paint_x), .paint_y(paint_y),
    .paint_color(paint_color), .paint_ack(paint_ack),
    .wipe_req(wipe_req), .wipe_color(wipe_color), .wiping(wiping),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    vga_req = 0; vga_x = 0; vga_y = 0;
    paint_req = 0; paint_x = 0; paint_y = 0; paint_color = 0;
    wipe_req = 0; wipe_color = 0;
    pre_we = 0; pre_addr = 0; pre_data = 0;
    step(); step();
    vectors++;
    if (all_outs !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_outs: got %h expected 0", all_outs);
    end
    clr = 1'b0;
    step();
    vectors++;
    if (all_outs !== 26'd0) begin
      miscompares++;
      $display("FAIL idle_outs: got %h expected 0", all_outs);
    end
  endtask

  task automatic test_paint();
    int writes;
    writes = 0;
    paint_req = 1; paint_x = 100; paint_y = 40; paint_color = 5;
    step();
    if (ram_en && ram_we) writes++;
    vectors++;
    if ({ram_en, ram_we, paint_ack} !== 3'b111) begin
      miscompares++;
      $display("FAIL paint_we_ack: got en/we/ack=%b expected 111", {ram_en, ram_we, paint_ack});
    end
    vectors++;
    if (ram_addr !== 15'd1625) begin
      miscompares++;
      $display("FAIL paint_addr: got %0d expected 1625", ram_addr);
    end
    vectors++;
    if (ram_wdata !== 3'd5) begin
      miscompares++;
      $display("FAIL paint_wdata: got %0d expected 5", ram_wdata);
    end
    // paint_req still held during the ack cycle
    step();
    if (ram_en && ram_we) writes++;
    vectors++;
    if (paint_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL paint_ack_pulse: got %b expected 0", paint_ack);
    end
    paint_req = 0;
    repeat (3) begin
      step();
      if (ram_en && ram_we) writes++;
    end
    vectors++;
    if (writes != 1) begin
      miscompares++;
      $display("FAIL paint_single_write: got %0d writes expected 1", writes);
    end
  endtask

  task automatic test_vga_stream();
    int k;
    logic [2:0] exp_c;
    for (int i = 0; i < 160; i++) begin
      pre_we = 1; pre_addr = 15'(i); pre_data = 3'((i * 3 + 1) & 7);
      step();
    end
    pre_we = 0;
    paint_req = 1; paint_x = 16; paint_y = 16; paint_color = 6;
    for (int c = 0; c < 644; c++) begin
      vga_req = (c < 640);
      vga_x = 10'(c);
      vga_y = 0;
      step();
      k = c - 2;
      vectors++;
      if (vga_valid !== ((k >= 0) && (k < 640))) begin
        miscompares++;
        $display("FAIL vga_valid[%0d]: got %b expected %b", c + 1, vga_valid, (k >= 0) && (k < 640));
      end
      if (k >= 0 && k < 640) begin
        exp_c = 3'((((k >> 2) * 3) + 1) & 7);
        vectors++;
        if (vga_color !== exp_c) begin
          miscompares++;
          $display("FAIL vga_color[x=%0d]: got %0d expected %0d", k, vga_color, exp_c);
        end
      end
      if (c < 640) begin
        vectors++;
        if (paint_ack !== 1'b0 || ram_we !== 1'b0) begin
          miscompares++;
          $display("FAIL vga_blocks_paint[%0d]: got ack/we=%b%b expected 00", c + 1, paint_ack, ram_we);
        end
      end else if (c == 640) begin
        vectors++;
        if ({paint_ack, ram_we, ram_addr} !== {2'b11, 15'd644}) begin
          miscompares++;
          $display("FAIL paint_after_vga: got ack/we=%b%b addr=%0d expected 11 addr=644", paint_ack, ram_we, ram_addr);
        end
        paint_req = 0;
      end else begin
        vectors++;
        if (paint_ack !== 1'b0) begin
          miscompares++;
          $display("FAIL paint_after_vga_pulse: got %b expected 0", paint_ack);
        end
      end
    end
    vga_req = 0;
  endtask

  task automatic test_out_of_range();
    logic [9:0] xs [0:1];
    logic [9:0] ys [0:1];
    xs[0] = 640; ys[0] = 0;
    xs[1] = 0;   ys[1] = 480;
    for (int i = 0; i < 2; i++) begin
      vga_req = 1; vga_x = xs[i]; vga_y = ys[i];
      step();
      vga_req = 0;
      vectors++;
      if (ram_en !== 1'b0) begin
        miscompares++;
        $display("FAIL oor_vga_no_ram[%0d]: got ram_en=%b expected 0", i, ram_en);
      end
      step(); step();
      vectors++;
      if ({vga_valid, vga_color} !== 4'b1000) begin
        miscompares++;
        $display("FAIL oor_vga_result[%0d]: got valid=%b color=%0d expected valid=1 color=0", i, vga_valid, vga_color);
      end
    end
    // Bottom-right corner is the last valid cell.
    vga_req = 1; vga_x = 639; vga_y = 479;
    step();
    vga_req = 0;
    vectors++;
    if ({ram_en, ram_we, ram_addr} !== {2'b10, 15'd19199}) begin
      miscompares++;
      $display("FAIL corner_read: got en/we=%b%b addr=%0d expected 10 addr=19199", ram_en, ram_we, ram_addr);
    end
    step(); step();
    paint_req = 1; paint_x = 700; paint_y = 10; paint_color = 7;
    step();
    vectors++;
    if ({paint_ack, ram_en, ram_we} !== 3'b100) begin
      miscompares++;
      $display("FAIL oor_paint: got ack/en/we=%b expected 100", {paint_ack, ram_en, ram_we});
    end
    paint_req = 0;
    step();
  endtask

  task automatic test_wipe();
    int exp_addr, wipe_cycles, acks, acks_in_wipe;
    exp_addr = 0; wipe_cycles = 0; acks = 0; acks_in_wipe = 0;
    wipe_req = 1; wipe_color = 3;
    step();
    wipe_req = 0; wipe_color = 0;
    vectors++;
    if (wiping !== 1'b1) begin
      miscompares++;
      $display("FAIL wipe_rise: got %b expected 1", wiping);
    end
    for (int c = 0; c < 19300; c++) begin
      if (wiping === 1'b1) wipe_cycles++;
      if (paint_ack === 1'b1) begin
        acks++;
        if (wiping === 1'b1) acks_in_wipe++;
        vectors++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 15'd322, 3'd2}) begin
          miscompares++;
          $display("FAIL wipe_paint_write: got we=%b addr=%0d data=%0d expected 1/322/2", ram_we, ram_addr, ram_wdata);
        end
        paint_req = 0;
      end else if (ram_en && ram_we) begin
        vectors++;
        if (ram_addr !== 15'(exp_addr) || ram_wdata !== 3'd3) begin
          miscompares++;
          $display("FAIL wipe_write: got addr=%0d data=%0d expected addr=%0d data=3", ram_addr, ram_wdata, exp_addr);
        end
        exp_addr++;
      end
      if (c == 50) begin wipe_req = 1; wipe_color = 5; end
      if (c == 51) begin wipe_req = 0; wipe_color = 0; end
      if (c == 100) begin paint_req = 1; paint_x = 8; paint_y = 8; paint_color = 2; end
      step();
    end
    paint_req = 0;
    vectors++;
    if (exp_addr != 19200) begin
      miscompares++;
      $display("FAIL wipe_count: got %0d writes expected 19200", exp_addr);
    end
    vectors++;
    if (wipe_cycles != 19200) begin
      miscompares++;
      $display("FAIL wipe_cycles: got %0d expected 19200", wipe_cycles);
    end
    vectors++;
    if (acks != 1 || acks_in_wipe != 0) begin
      miscompares++;
      $display("FAIL wipe_paint_ack: got %0d acks (%0d during wipe) expected 1 (0)", acks, acks_in_wipe);
    end
  endtask

  task automatic test_wipe_vga();
    int exp_addr, wipe_cycles, bad;
    exp_addr = 0; wipe_cycles = 0; bad = 0;
    wipe_req = 1; wipe_color = 6;
    vga_req = 1; vga_x = 0; vga_y = 0;
    step();
    wipe_req = 0;
    for (int c = 0; c < 38420; c++) begin
      if (wiping === 1'b1) wipe_cycles++;
      if (ram_en && ram_we) begin
        if (ram_addr !== 15'(exp_addr)) begin
          bad++;
          if (bad < 5)
            $display("FAIL wipe_vga_order: got addr=%0d expected %0d", ram_addr, exp_addr);
        end
        exp_addr++;
      end
      vga_req = (c % 2 == 1) && (c < 38410);
      step();
    end
    vga_req = 0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL wipe_vga_sequence: got %0d out-of-order writes expected 0", bad);
    end
    vectors++;
    if (exp_addr != 19200) begin
      miscompares++;
      $display("FAIL wipe_vga_count: got %0d writes expected 19200", exp_addr);
    end
    vectors++;
    if (wipe_cycles < 38399 || wipe_cycles > 38401) begin
      miscompares++;
      $display("FAIL wipe_vga_cycles: got %0d expected 38400 +/-1", wipe_cycles);
    end
  endtask

  task automatic test_reset_mid_wipe();
    int writes;
    writes = 0;
    wipe_req = 1; wipe_color = 1;
    step();
    wipe_req = 0;
    repeat (5000) step();
    vectors++;
    if ({wiping, ram_we} !== 2'b11) begin
      miscompares++;
      $display("FAIL mid_wipe_active: got wiping/we=%b%b expected 11", wiping, ram_we);
    end
    #2 clr = 1'b1;
    #1;
    vectors++;
    if (all_outs !== 26'd0) begin
      miscompares++;
      $display("FAIL async_clr: got %h expected 0", all_outs);
    end
    step();
    vectors++;
    if (all_outs !== 26'd0) begin
      miscompares++;
      $display("FAIL clr_held: got %h expected 0", all_outs);
    end
    clr = 1'b0;
    repeat (50) begin
      step();
      if (ram_en && ram_we) writes++;
    end
    vectors++;
    if (writes != 0 || wiping !== 1'b0) begin
      miscompares++;
      $display("FAIL post_clr_quiet: got %0d writes wiping=%b expected 0 writes wiping=0", writes, wiping);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_paint();
    test_vga_stream();
    test_out_of_range();
    test_wipe();
    test_wipe_vga();
    test_reset_mid_wipe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
